// File: rtl/adder_tree_2to1.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_2to1
// Brief    : Pipelined binary reduction adder tree. One register per level,
//            sum taken modulo 2^BIT_LEN, one term vector accepted per clock.
// Revision : 1.0  initial release
// ============================================================================
module adder_tree_2to1 #(
    parameter int NUM_ELEMENTS = 10,
    parameter int BIT_LEN      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [BIT_LEN-1:0] terms [NUM_ELEMENTS],
    output logic               out_valid,
    output logic [BIT_LEN-1:0] S
);

    function automatic int f_levels(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Entry count of level k: ceil(NUM_ELEMENTS / 2^k).
    function automatic int f_count(input int k);
        return (NUM_ELEMENTS + (1 << k) - 1) >> k;
    endfunction

    localparam int C_LEVELS = f_levels(NUM_ELEMENTS);

    // w_lvl[0] is the input vector; w_lvl[k+1] is the registered output of stage k.
    logic [BIT_LEN-1:0] w_lvl [C_LEVELS+1][NUM_ELEMENTS];
    logic [C_LEVELS-1:0] r_vld;

    assign w_lvl[0] = terms;

    for (genvar k = 0; k < C_LEVELS; k++) begin : g_level
        for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_entry
            if (j < f_count(k + 1)) begin : g_live
                logic [BIT_LEN-1:0] w_next;
                logic [BIT_LEN-1:0] r_sum;

                if (2 * j + 1 < f_count(k)) begin : g_pair
                    assign w_next = w_lvl[k][2*j] + w_lvl[k][2*j+1];
                end else begin : g_pass
                    // Odd leftover is still registered so every path has equal depth.
                    assign w_next = w_lvl[k][2*j];
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_sum <= '0;
                    end else begin
                        r_sum <= w_next;
                    end
                end

                assign w_lvl[k+1][j] = r_sum;
            end else begin : g_pad
                assign w_lvl[k+1][j] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= in_valid;
            for (int i = 1; i < C_LEVELS; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    assign out_valid = r_vld[C_LEVELS-1];
    assign S         = w_lvl[C_LEVELS][0];

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_2to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_2to1
// Brief    : Bench for adder_tree_2to1 at N=10, N=3 and N=1 against a
//            reference sum model with per-cycle expected-output tables.
// Revision : 1.0  initial release
// ============================================================================
module tb_adder_tree_2to1;

    localparam int BL   = 16;
    localparam int N10  = 10;
    localparam int N3   = 3;
    localparam int N1   = 1;
    localparam int L10  = 4;
    localparam int L3   = 2;
    localparam int L1   = 1;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          v10, v3, v1;
    logic [BL-1:0] t10 [N10];
    logic [BL-1:0] t3  [N3];
    logic [BL-1:0] t1  [N1];
    logic          ov10, ov3, ov1;
    logic [BL-1:0] s10, s3, s1;

    adder_tree_2to1 #(.NUM_ELEMENTS(N10), .BIT_LEN(BL)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(v10), .terms(t10), .out_valid(ov10), .S(s10));
    adder_tree_2to1 #(.NUM_ELEMENTS(N3), .BIT_LEN(BL)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .terms(t3), .out_valid(ov3), .S(s3));
    adder_tree_2to1 #(.NUM_ELEMENTS(N1), .BIT_LEN(BL)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .terms(t1), .out_valid(ov1), .S(s1));

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // Expected output per DUT per cycle: valid flag and sum.
    bit            ev [3][MAXC];
    logic [BL-1:0] es [3][MAXC];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record the sum each DUT must emit LEVELS cycles after this vector is sampled.
    task automatic commit();
        longint s;
        if (v10) begin
            s = 0;
            foreach (t10[i]) s += t10[i];
            ev[0][cyc+L10] = 1'b1;
            es[0][cyc+L10] = BL'(s);
        end
        if (v3) begin
            s = 0;
            foreach (t3[i]) s += t3[i];
            ev[1][cyc+L3] = 1'b1;
            es[1][cyc+L3] = BL'(s);
        end
        if (v1) begin
            s = 0;
            foreach (t1[i]) s += t1[i];
            ev[2][cyc+L1] = 1'b1;
            es[2][cyc+L1] = BL'(s);
        end
    endtask

    task automatic idle();
        v10 = 1'b0;
        v3  = 1'b0;
        v1  = 1'b0;
    endtask

    task automatic randomize_terms();
        bit all_ones;
        all_ones = ($urandom_range(0, 7) == 0);
        foreach (t10[i]) t10[i] = all_ones ? {BL{1'b1}} : BL'($urandom);
        foreach (t3[i])  t3[i]  = all_ones ? {BL{1'b1}} : BL'($urandom);
        foreach (t1[i])  t1[i]  = all_ones ? {BL{1'b1}} : BL'($urandom);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("vld10", 32'(ov10), 32'(ev[0][cyc]));
            chk("vld3",  32'(ov3),  32'(ev[1][cyc]));
            chk("vld1",  32'(ov1),  32'(ev[2][cyc]));
            if (ev[0][cyc]) chk("sum10", 32'(s10), 32'(es[0][cyc]));
            if (ev[1][cyc]) chk("sum3",  32'(s3),  32'(es[1][cyc]));
            if (ev[2][cyc]) chk("sum1",  32'(s1),  32'(es[2][cyc]));
        end
    end

    initial begin
        idle();
        foreach (t10[i]) t10[i] = '0;
        foreach (t3[i])  t3[i]  = '0;
        foreach (t1[i])  t1[i]  = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_vld10", 32'(ov10), 32'd0);
        chk("rst_s10",   32'(s10),  32'd0);
        chk("rst_vld3",  32'(ov3),  32'd0);
        chk("rst_s3",    32'(s3),   32'd0);
        chk("rst_vld1",  32'(ov1),  32'd0);
        chk("rst_s1",    32'(s1),   32'd0);
        mon_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single vectors on all three widths.
        v10 = 1'b1; v3 = 1'b1; v1 = 1'b1;
        foreach (t10[i]) t10[i] = 16'h0FFF;
        t3[0] = 16'd1; t3[1] = 16'd2; t3[2] = 16'd3;
        t1[0] = 16'h1234;
        commit();
        step();
        idle();
        @(negedge clk);
        #1 chk("lit_n1", 32'(s1), 32'h1234);
        step();
        @(negedge clk);
        #1 chk("lit_n3", 32'(s3), 32'd6);
        step();
        step();
        @(negedge clk);
        #1 chk("lit_n10", 32'(s10), 32'h9FF6);
        repeat (2) step();

        // Overflow: ten copies of 0xFFFF wrap to 0xFFF6.
        v10 = 1'b1;
        foreach (t10[i]) t10[i] = 16'hFFFF;
        commit();
        step();
        idle();
        repeat (3) step();
        @(negedge clk);
        #1 chk("lit_ovf", 32'(s10), 32'hFFF6);
        repeat (2) step();

        // Streaming i, 2i, 0 on consecutive cycles.
        v10 = 1'b1;
        foreach (t10[i]) t10[i] = BL'(i);
        commit();
        step();
        foreach (t10[i]) t10[i] = BL'(2 * i);
        commit();
        step();
        foreach (t10[i]) t10[i] = '0;
        commit();
        step();
        idle();
        repeat (6) step();

        // Bubble pattern 1,0,1.
        v10 = 1'b1; v3 = 1'b1; v1 = 1'b1;
        randomize_terms();
        commit();
        step();
        idle();
        randomize_terms();
        step();
        v10 = 1'b1; v3 = 1'b1; v1 = 1'b1;
        randomize_terms();
        commit();
        step();
        idle();
        repeat (6) step();

        // Reset mid-flight: vector in, reset asserted two cycles later between edges.
        v10 = 1'b1; v3 = 1'b1; v1 = 1'b1;
        randomize_terms();
        commit();
        step();
        idle();
        step();
        #2 rst_n = 1'b0;
        for (int d = 0; d < 3; d++)
            for (int c = cyc; c < MAXC; c++) ev[d][c] = 1'b0;
        #1;
        chk("mid_vld10", 32'(ov10), 32'd0);
        chk("mid_s10",   32'(s10),  32'd0);
        chk("mid_s3",    32'(s3),   32'd0);
        chk("mid_s1",    32'(s1),   32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        v10 = 1'b1; v3 = 1'b1; v1 = 1'b1;
        randomize_terms();
        commit();
        step();
        idle();
        repeat (6) step();

        // Random traffic with random bubbles.
        for (int n = 0; n < 400; n++) begin
            v10 = 1'($urandom_range(0, 1));
            v3  = 1'($urandom_range(0, 1));
            v1  = 1'($urandom_range(0, 1));
            randomize_terms();
            commit();
            step();
        end
        idle();
        repeat (8) step();

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_tree_2to1.md
Name: adder_tree_2to1

Overview:
- Pipelined, parameterised binary (2-to-1) reduction adder tree.
- Sums NUM_ELEMENTS unsigned BIT_LEN-bit terms into one BIT_LEN-bit result, modulo 2^BIT_LEN.
- Each tree level is registered, so one new term vector is accepted per clock.
- Used as a datapath reduction block wherever many same-width operands are summed.

Parameters:
- NUM_ELEMENTS, 10: number of input terms; legal range is 1 or more.
- BIT_LEN, 16: width of each term and of the result.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  terms are valid this cycle.
- terms  input  unpacked array [NUM_ELEMENTS] of BIT_LEN  unsigned operands.
- out_valid  output  1  S holds the sum of a vector accepted LEVELS cycles earlier.
- S  output  BIT_LEN  reduction sum.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Asserting rst_n low immediately clears:
  - every pipeline register, including S, to 0;
  - every level's valid bit, including out_valid, to 0.
- Release of reset is synchronous to clk.
- LEVELS = clog2(NUM_ELEMENTS), except LEVELS = 1 when NUM_ELEMENTS = 1.
- Level structure:
  - Level 0 is the terms input.
  - Level k+1 has ceil(n_k/2) entries, where n_k is the entry count of level k.
  - Each entry is the sum of a pair: entry j = entry 2j + entry 2j+1 of level k.
  - When n_k is odd, the last entry has no partner and passes through unchanged but is still registered, so path delay stays balanced.
- Every level output is a flop. Latency from input sample to S is exactly LEVELS clock cycles.
  - NUM_ELEMENTS=10 gives 4 cycles; 3 gives 2 cycles; 1 gives 1 cycle (registered passthrough).
- Arithmetic:
  - Unsigned; every adder is BIT_LEN wide.
  - Carries beyond BIT_LEN are discarded at every level.
  - S therefore equals (sum of all terms) mod 2^BIT_LEN.
- Throughput: one vector per cycle, with no backpressure and no stalls.
- Valid pipeline:
  - in_valid travels through a LEVELS-deep shift register and emerges as out_valid.
  - Data registers load every cycle regardless of in_valid.
  - S content while out_valid=0 is don't-care for checking, but must be deterministic: 0 after reset until real data reaches it.
- Back-to-back vectors produce back-to-back results in order.
- Bubbles in in_valid appear as identical bubbles in out_valid.
- Reset mid-operation: all in-flight vectors are discarded. out_valid stays 0 until LEVELS cycles after the first valid input following reset release.
- Implementation:
  - Generate loops over levels and entries, or an equivalent recursive instantiation of two half-trees plus one registered adder.
  - Both forms must meet the latency rule above, including the odd-count passthrough balancing.
- The block has no other outputs and no overflow flag.

Test Plan:
- Defaults (N=10, BIT_LEN=16): all terms = 0x0FFF, in_valid=1 for one cycle -> out_valid=1 exactly 4 cycles later with S=0x9FF6; out_valid=0 on every other cycle.
- Overflow: all terms = 0xFFFF -> S=0xFFF6, because 655350 mod 65536 = 65526.
- Streaming: vectors terms[i]=i, then terms[i]=2*i, then all zeros, applied on consecutive cycles -> S=45, 90, 0 on three consecutive cycles starting 4 cycles after the first; out_valid high for exactly 3 cycles.
- Odd count: N=3 with terms 1, 2, 3 -> S=6 after 2 cycles. N=1 with term 0x1234 -> S=0x1234 after 1 cycle.
- Reset mid-flight: apply a valid vector, pull rst_n low 2 cycles later (asynchronously, between edges) -> S=0 and out_valid=0 immediately, and no result ever emerges for that vector. A new vector after release gives the correct sum after 4 cycles.
- Bubble pattern: in_valid = 1,0,1 over three cycles -> out_valid = 1,0,1 delayed by 4 cycles, with correct sums in the two valid slots.
